// File: rtl/urv_dmem_wb_bridge.sv
// Responder for the uRV data-memory port: turns execute-stage load/store strobes into
// single-beat Wishbone classic cycles, with ack/err/timeout termination.
module urv_dmem_wb_bridge #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_BITS = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_load_i,
   input  logic        dm_store_i,
   output logic        dm_ready_o,
   output logic [31:0] dm_data_l_o,
   output logic        dm_load_done_o,
   output logic        dm_store_done_o,
   output logic        bus_error_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [TO_BITS-1:0]  r_cnt;
   logic [TO_BITS-1:0]  w_cnt_nxt;
   logic [31:0]         w_adr_nxt;
   logic [31:0]         w_dat_nxt;
   logic [3:0]          w_sel_nxt;
   logic                w_we_nxt;
   logic                w_cyc_nxt;
   logic [31:0]         w_data_l_nxt;
   logic                w_load_done_nxt;
   logic                w_store_done_nxt;
   logic                w_bus_error_nxt;
   logic                w_timeout;

   assign dm_ready_o = (r_state == ST_IDLE);
   assign wb_stb_o   = wb_cyc_o;
   assign w_timeout  = (r_cnt == TO_BITS'(TIMEOUT));

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_adr_nxt        = wb_adr_o;
      w_dat_nxt        = wb_dat_o;
      w_sel_nxt        = wb_sel_o;
      w_we_nxt         = wb_we_o;
      w_cyc_nxt        = wb_cyc_o;
      w_data_l_nxt     = dm_data_l_o;
      w_load_done_nxt  = 1'b0;
      w_store_done_nxt = 1'b0;
      w_bus_error_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // A simultaneous load is dropped: the store takes the bus
            if (dm_load_i || dm_store_i) begin
               w_adr_nxt   = dm_addr_i;
               w_dat_nxt   = dm_data_s_i;
               w_sel_nxt   = dm_data_select_i;
               w_we_nxt    = dm_store_i;
               w_cyc_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_BUS;
            end
         end
         ST_BUS: begin
            if (wb_ack_i) begin
               w_cyc_nxt   = 1'b0;
               w_we_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
               if (wb_we_o) begin
                  w_store_done_nxt = 1'b1;
               end else begin
                  w_load_done_nxt = 1'b1;
                  w_data_l_nxt    = wb_dat_i;
               end
            end else if (wb_err_i || w_timeout) begin
               w_cyc_nxt       = 1'b0;
               w_we_nxt        = 1'b0;
               w_state_nxt     = ST_IDLE;
               w_bus_error_nxt = 1'b1;
               if (wb_we_o) begin
                  w_store_done_nxt = 1'b1;
               end else begin
                  w_load_done_nxt = 1'b1;
                  w_data_l_nxt    = 32'h0;
               end
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + TO_BITS'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         wb_adr_o        <= '0;
         wb_dat_o        <= '0;
         wb_sel_o        <= '0;
         wb_we_o         <= 1'b0;
         wb_cyc_o        <= 1'b0;
         dm_data_l_o     <= '0;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         bus_error_o     <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_cnt           <= w_cnt_nxt;
         wb_adr_o        <= w_adr_nxt;
         wb_dat_o        <= w_dat_nxt;
         wb_sel_o        <= w_sel_nxt;
         wb_we_o         <= w_we_nxt;
         wb_cyc_o        <= w_cyc_nxt;
         dm_data_l_o     <= w_data_l_nxt;
         dm_load_done_o  <= w_load_done_nxt;
         dm_store_done_o <= w_store_done_nxt;
         bus_error_o     <= w_bus_error_nxt;
      end
   end

endmodule

// File: tb/tb_urv_dmem_wb_bridge.sv
// Bench for urv_dmem_wb_bridge: directed requests, a transaction-window model of the
// expected bus/done behaviour, and a per-cycle compare process.
module tb_urv_dmem_wb_bridge;

   localparam int unsigned TO  = 4;
   localparam int          NC  = 64;
   localparam int          END = 60;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] dm_addr_i, dm_data_s_i, wb_dat_i;
   logic [3:0]  dm_data_select_i;
   logic        dm_load_i, dm_store_i, wb_ack_i, wb_err_i;
   logic        dm_ready_o, dm_load_done_o, dm_store_done_o, bus_error_o;
   logic [31:0] dm_data_l_o, wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;

   urv_dmem_wb_bridge #(.TIMEOUT(TO), .TO_BITS(8)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
      .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_ready_o(dm_ready_o),
      .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
      .dm_store_done_o(dm_store_done_o), .bus_error_o(bus_error_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk = ~clk;

   // Stimulus tables, indexed by cycle
   bit        rst_at [NC];
   bit        ld_at  [NC];
   bit        st_at  [NC];
   bit        ack_at [NC];
   bit        err_at [NC];
   bit        dv_at  [NC];
   bit [31:0] adr_at [NC];
   bit [31:0] sd_at  [NC];
   bit [3:0]  sel_at [NC];
   bit [31:0] rd_at  [NC];

   // Expected behaviour, indexed by cycle
   bit        e_cyc  [NC];
   bit        e_we   [NC];
   bit [31:0] e_adr  [NC];
   bit [31:0] e_dat  [NC];
   bit [3:0]  e_sel  [NC];
   bit        e_ld   [NC];
   bit        e_st   [NC];
   bit        e_err  [NC];
   bit        e_dls  [NC];
   bit [31:0] e_dlv  [NC];
   bit        e_dlc  [NC];

   logic        obs_cyc [NC];
   logic        obs_st  [NC];
   logic [31:0] obs_dl  [NC];

   int          cyc_now = 0;
   int          n_vec   = 0;
   int          n_bad   = 0;
   logic [31:0] exp_dl  = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_now, act, exp);
      end
   endtask

   // req: 0 load, 1 store, 2 both strobes; w: slave wait states (-1 = silent);
   // kind: 0 ack, 1 err, 2 ack+err; rc: cycle in which rst_i is held (-1 = none)
   task automatic plan(input int n, input int req, input bit [31:0] addr, input bit [31:0] sdat,
                       input bit [3:0] sel, input int w, input int kind, input bit [31:0] rdat,
                       input int rc);
      bit is_st;
      bit good;
      int m, tend, e, last;
      is_st      = (req != 0);
      ld_at[n]   = (req != 1);
      st_at[n]   = is_st;
      adr_at[n]  = addr;
      sd_at[n]   = sdat;
      sel_at[n]  = sel;
      tend       = n + 1 + int'(TO);
      m          = (w < 0) ? NC + 100 : n + 1 + w;
      if (w >= 0) begin
         ack_at[m] = (kind != 1);
         err_at[m] = (kind != 0);
         dv_at[m]  = 1'b1;
         rd_at[m]  = rdat;
      end
      e    = (m < tend) ? m : tend;
      good = (m <= tend) && (kind != 1);
      last = e;
      if (rc >= 0 && rc <= e) begin
         last          = rc;
         rst_at[rc]    = 1'b1;
         e_dlc[rc + 1] = 1'b1;
      end
      for (int c = n + 1; c <= last; c++) begin
         e_cyc[c] = 1'b1;
         e_we[c]  = is_st;
         e_adr[c] = addr;
         e_dat[c] = sdat;
         e_sel[c] = sel;
      end
      if (last == e) begin
         e_st[e + 1]  = is_st;
         e_ld[e + 1]  = !is_st;
         e_err[e + 1] = !good;
         if (!is_st) begin
            e_dls[e + 1] = 1'b1;
            e_dlv[e + 1] = good ? rdat : 32'h0;
         end
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (cyc_now >= 3 && cyc_now < END) begin
         if (e_dlc[cyc_now]) exp_dl = 32'h0;
         if (e_dls[cyc_now]) exp_dl = e_dlv[cyc_now];
         obs_cyc[cyc_now] = wb_cyc_o;
         obs_st[cyc_now]  = dm_store_done_o;
         obs_dl[cyc_now]  = dm_data_l_o;
         chk("ready", 32'(dm_ready_o), 32'(!e_cyc[cyc_now]));
         chk("cyc", 32'(wb_cyc_o), 32'(e_cyc[cyc_now]));
         chk("stb", 32'(wb_stb_o), 32'(e_cyc[cyc_now]));
         chk("we", 32'(wb_we_o), 32'(e_we[cyc_now]));
         if (e_cyc[cyc_now]) begin
            chk("adr", wb_adr_o, e_adr[cyc_now]);
            chk("wdat", wb_dat_o, e_dat[cyc_now]);
            chk("sel", 32'(wb_sel_o), 32'(e_sel[cyc_now]));
         end
         chk("load_done", 32'(dm_load_done_o), 32'(e_ld[cyc_now]));
         chk("store_done", 32'(dm_store_done_o), 32'(e_st[cyc_now]));
         chk("bus_error", 32'(bus_error_o), 32'(e_err[cyc_now]));
         chk("data_l", dm_data_l_o, exp_dl);
      end
   end

   initial begin
      int ncyc;
      rst_at[0] = 1'b1; rst_at[1] = 1'b1; rst_at[2] = 1'b1;
      // load with 2 wait states
      plan(5,  0, 32'h0000_0100, 32'h0,         4'b1111, 2,  0, 32'hCAFE_BABE, -1);
      // zero-wait byte store
      plan(12, 1, 32'h0000_0203, 32'h5555_5555, 4'b1000, 0,  0, 32'h0,         -1);
      // silent slave -> timeout, plus an ignored strobe mid-cycle
      plan(18, 0, 32'h0000_0400, 32'h0,         4'b1111, -1, 0, 32'h0,         -1);
      st_at[20] = 1'b1; adr_at[20] = 32'h0000_0999; sel_at[20] = 4'b0001;
      // good load, then an err-terminated load
      plan(26, 0, 32'h0000_0500, 32'h0,         4'b1111, 0,  0, 32'h1234_5678, -1);
      plan(30, 0, 32'h0000_0504, 32'h0,         4'b1111, 1,  1, 32'hDEAD_BEEF, -1);
      // store then load strobed in the store's done cycle; ack+err together
      plan(36, 1, 32'h0000_0600, 32'h0102_0304, 4'b0011, 0,  0, 32'h0,         -1);
      plan(38, 0, 32'h0000_0604, 32'h0,         4'b1111, 1,  2, 32'hA5A5_F00D, -1);
      // reset mid-cycle, then a late ack
      plan(44, 0, 32'h0000_0700, 32'h0,         4'b1111, -1, 0, 32'h0,         47);
      ack_at[49] = 1'b1; dv_at[49] = 1'b1; rd_at[49] = 32'hFFFF_FFFF;
      // load and store strobed together
      plan(52, 2, 32'h0000_0300, 32'h0BAD_F00D, 4'b1111, 1,  0, 32'h7777_7777, -1);

      for (int c = 0; c < END; c++) begin
         cyc_now          = c;
         rst_i            = rst_at[c];
         dm_load_i        = ld_at[c];
         dm_store_i       = st_at[c];
         dm_addr_i        = (ld_at[c] || st_at[c]) ? adr_at[c] : $urandom;
         dm_data_s_i      = (ld_at[c] || st_at[c]) ? sd_at[c] : $urandom;
         dm_data_select_i = (ld_at[c] || st_at[c]) ? sel_at[c] : 4'($urandom);
         wb_ack_i         = ack_at[c];
         wb_err_i         = err_at[c];
         wb_dat_i         = dv_at[c] ? rd_at[c] : $urandom;
         @(posedge clk);
         #1;
      end
      cyc_now = END;

      // Hand-computed anchors for the model
      ncyc = 0;
      for (int c = 5; c < 12; c++) ncyc += int'(obs_cyc[c] === 1'b1);
      chk("lit_t1_cyc_len", 32'(ncyc), 32'd3);
      chk("lit_t1_data", obs_dl[9], 32'hCAFE_BABE);
      chk("lit_t2_store_done", 32'(obs_st[14]), 32'd1);
      ncyc = 0;
      for (int c = 18; c < 26; c++) ncyc += int'(obs_cyc[c] === 1'b1);
      chk("lit_t3_cyc_len", 32'(ncyc), 32'd5);
      chk("lit_t3_data", obs_dl[24], 32'h0);
      chk("lit_t4_data", obs_dl[41], 32'hA5A5_F00D);
      chk("lit_t5_data_reset", obs_dl[48], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
